// File: rtl/histogram_pkg.sv
// ---------------------------------------------------------------------------
// histogram_pkg
// Shared constants and types for the gray-level histogram block.
//   GRAY_W   : width of a gray sample (bin address)
//   CNT_W    : width of one bin counter
//   NUM_BINS : number of bins (2**GRAY_W)
//   CNT_MAX  : saturation value of a bin counter
//   op_e     : operation carried down the pipeline for one sample slot
// ---------------------------------------------------------------------------
package histogram_pkg;

   localparam int GRAY_W   = 8;
   localparam int CNT_W    = 20;
   localparam int NUM_BINS = 2 ** GRAY_W;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_INC  = 2'd1,
      OP_CLR  = 2'd2
   } op_e;

endpackage

// File: rtl/histogram_ram.sv
// ---------------------------------------------------------------------------
// histogram_ram
// NUM_BINS x DW simple dual-port RAM: one write port, one synchronous read
// port. A read and a write to the same address on the same edge return the
// old contents; the top level forwards around that. Contents are not reset.
// Ports:
//   clk     : clock
//   wr_en   : write enable
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address, sampled on the rising edge
//   rd_data : registered read data, valid the cycle after rd_addr
// ---------------------------------------------------------------------------
module histogram_ram
   import histogram_pkg::*;
#(
   parameter int DW = CNT_W
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [GRAY_W-1:0] wr_addr,
   input  logic [DW-1:0]     wr_data,
   input  logic [GRAY_W-1:0] rd_addr,
   output logic [DW-1:0]     rd_data
);

   logic [DW-1:0] mem_q [0:NUM_BINS-1];
   logic [DW-1:0] rd_data_q;

   // Storage array and read register; left without reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
      rd_data_q <= mem_q[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/histogram.sv
// ---------------------------------------------------------------------------
// histogram
// Gray-level histogram with a 2-stage read-modify-write pipeline.
//   stage 1 : sample registered, RAM read issued on iGray
//   stage 2 : forwarded count registered (also the output), then written
//             back as count+1 (saturating) or as 0 for a clear slot
// Clear slots travel down the same pipeline as increments, so the single
// RAM write port never sees two writers in one cycle and an increment that
// is already in flight when iClear rises still lands before any clear write.
// Ports:
//   iClk       : clock
//   iRst_n     : asynchronous active-low reset
//   iClear     : level; each high cycle zeroes bin clr_addr and advances it
//   iInc       : level; counts iGray when iClear is low
//   iGray      : gray sample / read address
//   oGray      : iGray delayed 2 cycles
//   oGrayHisto : count of bin oGray (pre-increment for an incrementing sample)
// CNT_BITS defaults to CNT_W; smaller values give a narrower saturating bin.
// ---------------------------------------------------------------------------
module histogram
   import histogram_pkg::*;
#(
   parameter int CNT_BITS = CNT_W
) (
   input  logic                iClk,
   input  logic                iRst_n,
   input  logic                iClear,
   input  logic                iInc,
   input  logic [GRAY_W-1:0]   iGray,
   output logic [GRAY_W-1:0]   oGray,
   output logic [CNT_BITS-1:0] oGrayHisto
);

   localparam logic [CNT_BITS-1:0] SAT_MAX  = CNT_MAX[CNT_BITS-1:0];
   localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};
   localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
   localparam logic [GRAY_W-1:0]   GRAY_ONE = {{(GRAY_W-1){1'b0}}, 1'b1};
   localparam logic [GRAY_W-1:0]   GRAY_ZERO = {GRAY_W{1'b0}};

   // clear address counter
   logic [GRAY_W-1:0]   clr_addr_q, clr_addr_d;
   // stage 1
   op_e                 s1_op_q, s1_op_d;
   logic [GRAY_W-1:0]   s1_gray_q, s1_gray_d;
   logic [GRAY_W-1:0]   s1_waddr_q, s1_waddr_d;
   // stage 2 (gray and count double as the output registers)
   op_e                 s2_op_q, s2_op_d;
   logic [GRAY_W-1:0]   s2_gray_q, s2_gray_d;
   logic [GRAY_W-1:0]   s2_waddr_q, s2_waddr_d;
   logic [CNT_BITS-1:0] s2_cnt_q, s2_cnt_d;
   // copy of the previous RAM write, not yet visible through the read port
   logic                lw_vld_q, lw_vld_d;
   logic [GRAY_W-1:0]   lw_addr_q, lw_addr_d;
   logic [CNT_BITS-1:0] lw_data_q, lw_data_d;

   logic                wr_en;
   logic [GRAY_W-1:0]   wr_addr;
   logic [CNT_BITS-1:0] wr_data;
   logic [CNT_BITS-1:0] inc_val;
   logic [CNT_BITS-1:0] rd_data;
   logic [CNT_BITS-1:0] fwd_cnt;

   histogram_ram #(
      .DW (CNT_BITS)
   ) u_ram (
      .clk     (iClk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (iGray),
      .rd_data (rd_data)
   );

   // Write-port priority mux (clear over increment) with the saturating adder.
   always_comb begin
      inc_val = (s2_cnt_q == SAT_MAX) ? SAT_MAX : (s2_cnt_q + CNT_ONE);
      wr_addr = s2_waddr_q;
      if (s2_op_q == OP_CLR) begin
         wr_en   = 1'b1;
         wr_data = CNT_ZERO;
      end else if (s2_op_q == OP_INC) begin
         wr_en   = 1'b1;
         wr_data = inc_val;
      end else begin
         wr_en   = 1'b0;
         wr_data = CNT_ZERO;
      end
   end

   // Forwarding and next-state logic for the clear counter and both stages.
   always_comb begin
      // The write happening this cycle is newest, then last cycle's write,
      // which the RAM read on the same edge missed.
      if (wr_en && (wr_addr == s1_gray_q)) begin
         fwd_cnt = wr_data;
      end else if (lw_vld_q && (lw_addr_q == s1_gray_q)) begin
         fwd_cnt = lw_data_q;
      end else begin
         fwd_cnt = rd_data;
      end

      if (iClear) begin
         clr_addr_d = clr_addr_q + GRAY_ONE;
         s1_op_d    = OP_CLR;
         s1_waddr_d = clr_addr_q;
      end else if (iInc) begin
         clr_addr_d = clr_addr_q;
         s1_op_d    = OP_INC;
         s1_waddr_d = iGray;
      end else begin
         clr_addr_d = clr_addr_q;
         s1_op_d    = OP_NONE;
         s1_waddr_d = iGray;
      end
      s1_gray_d  = iGray;

      s2_op_d    = s1_op_q;
      s2_gray_d  = s1_gray_q;
      s2_waddr_d = s1_waddr_q;
      s2_cnt_d   = fwd_cnt;

      lw_vld_d   = wr_en;
      lw_addr_d  = wr_addr;
      lw_data_d  = wr_data;
   end

   // Pipeline, clear counter and last-write registers; reset empties the pipe.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         clr_addr_q <= GRAY_ZERO;
         s1_op_q    <= OP_NONE;
         s1_gray_q  <= GRAY_ZERO;
         s1_waddr_q <= GRAY_ZERO;
         s2_op_q    <= OP_NONE;
         s2_gray_q  <= GRAY_ZERO;
         s2_waddr_q <= GRAY_ZERO;
         s2_cnt_q   <= CNT_ZERO;
         lw_vld_q   <= 1'b0;
         lw_addr_q  <= GRAY_ZERO;
         lw_data_q  <= CNT_ZERO;
      end else begin
         clr_addr_q <= clr_addr_d;
         s1_op_q    <= s1_op_d;
         s1_gray_q  <= s1_gray_d;
         s1_waddr_q <= s1_waddr_d;
         s2_op_q    <= s2_op_d;
         s2_gray_q  <= s2_gray_d;
         s2_waddr_q <= s2_waddr_d;
         s2_cnt_q   <= s2_cnt_d;
         lw_vld_q   <= lw_vld_d;
         lw_addr_q  <= lw_addr_d;
         lw_data_q  <= lw_data_d;
      end
   end

   assign oGray      = s2_gray_q;
   assign oGrayHisto = s2_cnt_q;

endmodule

// File: tb/tb_histogram.sv
// ---------------------------------------------------------------------------
// tb_histogram
// Drives a full-width histogram and a 4-bit-bin copy with identical stimulus.
// Each applied sample pushes its expected oGray/oGrayHisto (from a bench-side
// bin model) to a queue; the entry is popped and compared two cycles later.
// Count values are only compared on plain read slots that follow at least two
// idle cycles after the last increment.
// ---------------------------------------------------------------------------
module tb_histogram;
   import histogram_pkg::*;

   localparam int SMALL_W   = 4;
   localparam int SMALL_MAX = 15;
   localparam int FRAME_N   = 5120;

   logic        iClk = 1'b0;
   logic        iRst_n;
   logic        iClear;
   logic        iInc;
   logic [7:0]  iGray;
   logic [7:0]  gray_big;
   logic [7:0]  gray_small;
   logic [19:0] histo_big;
   logic [3:0]  histo_small;

   histogram u_big (
      .iClk       (iClk),
      .iRst_n     (iRst_n),
      .iClear     (iClear),
      .iInc       (iInc),
      .iGray      (iGray),
      .oGray      (gray_big),
      .oGrayHisto (histo_big)
   );

   histogram #(
      .CNT_BITS (SMALL_W)
   ) u_small (
      .iClk       (iClk),
      .iRst_n     (iRst_n),
      .iClear     (iClear),
      .iInc       (iInc),
      .iGray      (iGray),
      .oGray      (gray_small),
      .oGrayHisto (histo_small)
   );

   always #5 iClk = ~iClk;

   typedef struct {
      logic [7:0] gray;
      int         exp_big;
      int         exp_small;
      bit         chk;
   } exp_t;

   exp_t sb_q[$];
   int   model_big[256];
   int   model_small[256];
   int   model_clr;
   int   n_vec;
   int   n_err;
   int   sum_big;
   bit   sum_en;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Apply one sample for one cycle, update the model, compare the sample from two cycles back.
   task automatic drive(input bit clr, input bit inc, input logic [7:0] g, input bit chk);
      exp_t e;
      iClear = clr;
      iInc   = inc;
      iGray  = g;
      e.gray      = g;
      e.exp_big   = model_big[g];
      e.exp_small = model_small[g];
      e.chk       = chk;
      sb_q.push_back(e);
      if (clr) begin
         model_big[model_clr]   = 0;
         model_small[model_clr] = 0;
         model_clr = (model_clr + 1) % 256;
      end else if (inc) begin
         if (model_big[g] < 1048575) model_big[g]++;
         if (model_small[g] < SMALL_MAX) model_small[g]++;
      end
      @(posedge iClk);
      #1;
      if (sb_q.size() >= 2) begin
         e = sb_q.pop_front();
         check_val($sformatf("gray_big[%02h]", e.gray), {24'd0, gray_big}, {24'd0, e.gray});
         check_val($sformatf("gray_small[%02h]", e.gray), {24'd0, gray_small}, {24'd0, e.gray});
         if (e.chk) begin
            check_val($sformatf("histo_big[%02h]", e.gray), {12'd0, histo_big}, e.exp_big);
            check_val($sformatf("histo_small[%02h]", e.gray), {28'd0, histo_small}, e.exp_small);
            if (sum_en) sum_big += int'(histo_big);
         end
      end
   endtask

   task automatic gap();
      repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic read_bin(input logic [7:0] g);
      drive(1'b0, 1'b0, g, 1'b1);
   endtask

   task automatic read_all();
      for (int i = 0; i < 256; i++) read_bin(i[7:0]);
   endtask

   task automatic clear_all();
      for (int i = 0; i < 256; i++) drive(1'b1, 1'b0, i[7:0], 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_gray_big"}, {24'd0, gray_big}, 32'd0);
      check_val({tag, "_histo_big"}, {12'd0, histo_big}, 32'd0);
      check_val({tag, "_gray_small"}, {24'd0, gray_small}, 32'd0);
      check_val({tag, "_histo_small"}, {28'd0, histo_small}, 32'd0);
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      sum_big   = 0;
      sum_en    = 1'b0;
      model_clr = 0;
      for (int i = 0; i < 256; i++) begin
         model_big[i]   = 0;
         model_small[i] = 0;
      end
      iRst_n = 1'b0;
      iClear = 1'b0;
      iInc   = 1'b0;
      iGray  = 8'h00;
      repeat (3) @(posedge iClk);
      #1;
      check_reset_outputs("reset");
      iRst_n = 1'b1;

      // Clear sweep, then every bin reads back as zero.
      clear_all();
      read_all();

      // Single sample into 0x37, neighbours untouched.
      drive(1'b0, 1'b1, 8'h37, 1'b0);
      gap();
      read_bin(8'h37);
      read_bin(8'h36);
      read_bin(8'h38);

      // Back-to-back hazard: 1000 x 0xFF then alternating 0x10/0x11.
      repeat (1000) drive(1'b0, 1'b1, 8'hFF, 1'b0);
      for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, (i % 2 == 0) ? 8'h10 : 8'h11, 1'b0);
      gap();
      read_bin(8'hFF);
      read_bin(8'h10);
      read_bin(8'h11);

      // Scaled frame: 20 samples per bin, then read and sum all bins.
      clear_all();
      for (int i = 0; i < FRAME_N; i++) drive(1'b0, 1'b1, i[7:0], 1'b0);
      gap();
      sum_big = 0;
      sum_en  = 1'b1;
      read_all();
      gap();
      sum_en  = 1'b0;
      check_val("frame_sum", sum_big, FRAME_N);

      // Increment in flight as clear starts, clear beats simultaneous inc,
      // clear paused mid-sweep with increments in between.
      drive(1'b0, 1'b1, 8'h06, 1'b0);
      repeat (100) drive(1'b1, 1'b1, 8'h05, 1'b0);
      repeat (5) drive(1'b0, 1'b1, 8'h90, 1'b0);
      repeat (156) drive(1'b1, 1'b1, 8'h05, 1'b0);
      read_all();

      // Mid-stream reset: 0x41 samples are still in the pipe when reset hits.
      repeat (7) drive(1'b0, 1'b1, 8'h20, 1'b0);
      repeat (3) drive(1'b0, 1'b1, 8'h40, 1'b0);
      repeat (2) drive(1'b0, 1'b1, 8'h41, 1'b0);
      iRst_n = 1'b0;
      iInc   = 1'b0;
      iClear = 1'b0;
      sb_q.delete();
      model_big[8'h41]   -= 2;
      model_small[8'h41] -= 2;
      model_clr = 0;
      @(posedge iClk);
      #1;
      check_reset_outputs("midrst");
      iRst_n = 1'b1;
      @(posedge iClk);
      #1;
      check_reset_outputs("rst_release");
      read_bin(8'h20);
      read_bin(8'h40);
      read_bin(8'h41);
      read_bin(8'hFF);
      gap();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
